// File: rtl/fifo_stream_reader.sv
// Drains a registered-output FIFO into a valid/ready stream: read in N, word valid in N+2.
// Read strobes stop once buffered plus pending words would exceed two, so backpressure never drops data.
module fifo_stream_reader #(
   parameter int WIDTH_DATA = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  en_i,
   input  logic                  fifo_empty_i,
   input  logic [WIDTH_DATA-1:0] fifo_data_i,
   output logic                  fifo_read_o,
   output logic                  m_valid_o,
   input  logic                  m_ready_i,
   output logic [WIDTH_DATA-1:0] m_data_o,
   output logic                  busy_o,
   output logic [CNT_WIDTH-1:0]  word_cnt_o
);

   logic [1:0]            cnt_q, cnt_d;
   logic                  rd_pend_q, rd_pend_d;
   logic                  head_q, head_d;
   logic                  tail_q, tail_d;
   logic [WIDTH_DATA-1:0] buf_q [0:1];
   logic [WIDTH_DATA-1:0] buf_d [0:1];
   logic [CNT_WIDTH-1:0]  word_cnt_q, word_cnt_d;
   logic                  pop;
   logic [1:0]            credit;

   always_comb begin
      pop    = (cnt_q != 2'd0) && m_ready_i;
      // Occupancy after this cycle, counting the word already requested from the FIFO.
      credit = cnt_q + {1'b0, rd_pend_q} - {1'b0, pop};
      fifo_read_o = rst_ni && en_i && !fifo_empty_i && (credit < 2'd2);

      rd_pend_d  = fifo_read_o;
      head_d     = head_q;
      tail_d     = tail_q;
      buf_d[0]   = buf_q[0];
      buf_d[1]   = buf_q[1];
      word_cnt_d = word_cnt_q;

      if (rd_pend_q) begin
         buf_d[tail_q] = fifo_data_i;
         tail_d        = ~tail_q;
      end
      if (pop) begin
         head_d     = ~head_q;
         word_cnt_d = word_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
      cnt_d = cnt_q + {1'b0, rd_pend_q} - {1'b0, pop};
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q      <= 2'd0;
         rd_pend_q  <= 1'b0;
         head_q     <= 1'b0;
         tail_q     <= 1'b0;
         buf_q[0]   <= '0;
         buf_q[1]   <= '0;
         word_cnt_q <= '0;
      end else begin
         cnt_q      <= cnt_d;
         rd_pend_q  <= rd_pend_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         buf_q[0]   <= buf_d[0];
         buf_q[1]   <= buf_d[1];
         word_cnt_q <= word_cnt_d;
      end
   end

   assign m_valid_o  = (cnt_q != 2'd0);
   assign m_data_o   = buf_q[head_q];
   assign busy_o     = rd_pend_q || (cnt_q != 2'd0);
   assign word_cnt_o = word_cnt_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural one-cycle-latency FIFO and an in-order scoreboard.
module tb_fifo_stream_reader;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       en = 1'b0;
   logic       m_ready = 1'b0;
   logic       fifo_empty, fifo_read, m_valid, busy;
   logic [7:0] fifo_data, m_data;
   logic [15:0] word_cnt;
   logic       fifo_read4, m_valid4, busy4;
   logic [7:0] m_data4;
   logic [3:0] word_cnt4;

   logic [7:0] mem [0:2047];
   int wr_ptr = 0;
   int rd_ptr;
   int exp_ptr;
   int total = 0;
   int bad = 0;
   int cnt_m;
   bit rd_pend_m;
   int pops;
   int reads;
   bit hold_pend;
   logic [7:0] hold_dat;

   typedef struct packed {
      logic        en;
      logic        rdy;
      logic        read;
      logic        valid;
      logic [7:0]  data;
      logic        busy;
      logic [15:0] wcnt;
   } vec_t;
   vec_t tbl [0:7];

   always #5 clk = ~clk;

   fifo_stream_reader #(.WIDTH_DATA(8), .CNT_WIDTH(16)) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .en_i(en), .fifo_empty_i(fifo_empty),
      .fifo_data_i(fifo_data), .fifo_read_o(fifo_read), .m_valid_o(m_valid),
      .m_ready_i(m_ready), .m_data_o(m_data), .busy_o(busy), .word_cnt_o(word_cnt));

   fifo_stream_reader #(.WIDTH_DATA(8), .CNT_WIDTH(4)) u_dut4 (
      .clk_i(clk), .rst_ni(rst_n), .en_i(en), .fifo_empty_i(fifo_empty),
      .fifo_data_i(fifo_data), .fifo_read_o(fifo_read4), .m_valid_o(m_valid4),
      .m_ready_i(m_ready), .m_data_o(m_data4), .busy_o(busy4), .word_cnt_o(word_cnt4));

   // FIFO model: registered data_out, one-cycle read latency, emptied by reset.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr    <= wr_ptr;
         fifo_data <= '0;
      end else if (fifo_read && rd_ptr != wr_ptr) begin
         fifo_data <= mem[rd_ptr];
         rd_ptr    <= rd_ptr + 1;
      end
   end
   assign fifo_empty = (rd_ptr == wr_ptr);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
      end
   endtask

   task automatic load(input int n, input int first);
      for (int i = 0; i < n; i++) begin
         mem[wr_ptr] = 8'(first + i);
         wr_ptr++;
      end
   endtask

   task automatic load_rand(input int n);
      for (int i = 0; i < n; i++) begin
         mem[wr_ptr] = 8'($urandom_range(0, 255));
         wr_ptr++;
      end
   endtask

   // Per-cycle checks at the falling edge, then advance the occupancy model.
   task automatic sample();
      bit pop;
      @(negedge clk);
      pop = m_valid && m_ready;
      chk("rd_when_empty", {31'b0, fifo_read && fifo_empty}, 0);
      chk("rd4_when_empty", {31'b0, fifo_read4 && fifo_empty}, 0);
      chk("valid", {31'b0, m_valid}, {31'b0, cnt_m != 0});
      chk("valid4", {31'b0, m_valid4}, {31'b0, cnt_m != 0});
      chk("cap_at_full", {31'b0, rd_pend_m && cnt_m == 2}, 0);
      chk("busy", {31'b0, busy}, {31'b0, rd_pend_m || cnt_m != 0});
      chk("busy4", {31'b0, busy4}, {31'b0, rd_pend_m || cnt_m != 0});
      chk("word_cnt", {16'b0, word_cnt}, {16'b0, pops[15:0]});
      chk("word_cnt4", {28'b0, word_cnt4}, {28'b0, pops[3:0]});
      if (hold_pend) chk("hold_dat", {24'b0, m_data}, {24'b0, hold_dat});
      if (pop) begin
         chk("pop_dat", {24'b0, m_data}, {24'b0, mem[exp_ptr]});
         chk("pop_dat4", {24'b0, m_data4}, {24'b0, mem[exp_ptr]});
         exp_ptr++;
         pops++;
      end
      if (fifo_read) reads++;
      hold_pend = m_valid && !m_ready;
      hold_dat  = m_data;
      cnt_m     = cnt_m + int'(rd_pend_m) - int'(pop);
      rd_pend_m = fifo_read;
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      sample();
      advance();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_read", {31'b0, fifo_read}, 0);
      chk("rst_valid", {31'b0, m_valid}, 0);
      chk("rst_data", {24'b0, m_data}, 0);
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_cnt", {16'b0, word_cnt}, 0);
      cnt_m     = 0;
      rd_pend_m = 1'b0;
      pops      = 0;
      reads     = 0;
      hold_pend = 1'b0;
      exp_ptr   = wr_ptr;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int n;
      // Backpressure from a fresh reset with 10 words: two reads, then one per pop.
      tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'd0};
      tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 16'd0};
      tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 16'd0};
      tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 16'd0};
      tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 1'b1, 16'd0};
      tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h02, 1'b1, 16'd1};
      tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h02, 1'b1, 16'd1};
      tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h02, 1'b1, 16'd1};

      #2;
      do_reset();

      // Streaming: 50 back-to-back words.
      load(50, 1);
      en = 1'b1;
      m_ready = 1'b1;
      for (int k = 0; k < 54; k++) begin
         sample();
         chk("stream_read", {31'b0, fifo_read}, {31'b0, k < 50});
         chk("stream_valid", {31'b0, m_valid}, {31'b0, k >= 2 && k < 52});
         chk("stream_busy", {31'b0, busy}, {31'b0, k >= 1 && k < 52});
         advance();
      end
      chk("stream_cnt", {16'b0, word_cnt}, 50);

      // Reset mid-stream with the buffer full.
      do_reset();
      load(10, 8'h40);
      en = 1'b1;
      m_ready = 1'b0;
      for (int k = 0; k < 3; k++) tick();
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      tick();
      chk("pre_rst_cnt", {16'b0, word_cnt}, 1);
      chk("pre_rst_data", {24'b0, m_data}, 8'h41);
      #2;
      do_reset();
      m_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         sample();
         chk("post_rst_read", {31'b0, fifo_read}, 0);
         advance();
      end

      // Backpressure vectors, then full drain.
      do_reset();
      load(10, 1);
      for (int i = 0; i < 8; i++) begin
         en = tbl[i].en;
         m_ready = tbl[i].rdy;
         sample();
         chk("bp_read", {31'b0, fifo_read}, {31'b0, tbl[i].read});
         chk("bp_valid", {31'b0, m_valid}, {31'b0, tbl[i].valid});
         chk("bp_data", {24'b0, m_data}, {24'b0, tbl[i].data});
         chk("bp_busy", {31'b0, busy}, {31'b0, tbl[i].busy});
         chk("bp_cnt", {16'b0, word_cnt}, {16'b0, tbl[i].wcnt});
         advance();
      end
      m_ready = 1'b1;
      n = 0;
      while (pops < 10 && n < 50) begin
         tick();
         n++;
      end
      chk("bp_drain", pops, 10);
      chk("bp_reads", reads, 10);

      // Random ready over 1000 random words.
      do_reset();
      load_rand(1000);
      en = 1'b1;
      n = 0;
      while (pops < 1000 && n < 6000) begin
         m_ready = 1'($urandom_range(0, 1));
         tick();
         n++;
      end
      chk("rand_drain", pops, 1000);

      // Enable dropped one cycle after the first read.
      do_reset();
      load(5, 8'h90);
      en = 1'b1;
      m_ready = 1'b1;
      tick();
      en = 1'b0;
      for (int k = 0; k < 8; k++) begin
         sample();
         chk("gate_read", {31'b0, fifo_read}, 0);
         advance();
      end
      chk("gate_reads", reads, 1);
      chk("gate_cnt", {16'b0, word_cnt}, 1);

      // Counter wrap on the 4-bit instance.
      do_reset();
      load(17, 8'hA0);
      en = 1'b1;
      m_ready = 1'b1;
      n = 0;
      while (pops < 17 && n < 100) begin
         tick();
         n++;
      end
      chk("wrap_cnt4", {28'b0, word_cnt4}, 1);
      chk("wrap_cnt16", {16'b0, word_cnt}, 17);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
